bt_cmd_ctrl: RTL and testbench

Parametrised command decoder/controller for the MP3 player's Bluetooth path, sitting between the UART byte receiver and the player/VS1003 control logic. It consumes one-cycle-strobed bytes from the receiver and drives the current track index and the packed left/right attenuation word. Over the previous controller it adds:
- parametrised track count, volume step and limits;
- a valid-strobe handshake instead of level sampling;
- per-command rate limiting;
- a two-byte absolute-volume command with timeout;
- mute with restore;
- ack/error/track-change pulses.

---
 rtl/bt_cmd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_bt_cmd_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bt_cmd_ctrl.sv
// Bluetooth command decoder: turns strobed UART bytes into track index,
// packed L/R attenuation, mute state and ack/error/track-change pulses.
module bt_cmd_ctrl #(
    parameter int         NUM_TRACKS  = 4,
    parameter int         TRACK_W     = 4,
    parameter logic [7:0] VOL_STEP    = 8'h10,
    parameter logic [7:0] VOL_MAX     = 8'hF0,
    parameter logic [7:0] VOL_RST     = 8'h20,
    parameter logic [7:0] MUTE_VAL    = 8'hFE,
    parameter int         HOLDOFF     = 5000000,
    parameter int         ARG_TIMEOUT = 50000000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [15:0]        vol,
    output logic [TRACK_W-1:0] CURRENT,
    output logic               track_chg,
    output logic               cmd_ack,
    output logic               cmd_err,
    output logic               muted
);

    typedef enum logic {IDLE, WAIT_ARG} state_t;

    localparam logic [7:0]         TRK_HI   = 8'(8'hA0 + NUM_TRACKS);
    localparam logic [TRACK_W-1:0] TRK_LAST = TRACK_W'(NUM_TRACKS - 1);
    localparam logic [31:0]        HO_LOAD  = 32'(HOLDOFF - 1);
    localparam logic [31:0]        TO_LAST  = 32'(ARG_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [TRACK_W-1:0] cur_q, cur_d;
    logic [7:0]         vl_q, vl_d, vr_q, vr_d;
    logic               muted_q, muted_d;
    logic [15:0]        vol_q, vol_d;
    logic [31:0]        ho_q, ho_d, to_q, to_d;
    logic               chg_q, chg_d, ack_q, ack_d, err_q, err_d;
    logic               step_ok;

    // 9-bit arithmetic: the borrow/carry bit flags saturation.
    function automatic logic [7:0] vol_dn(input logic [7:0] v);
        logic [8:0] s;
        s = {1'b0, v} - {1'b0, VOL_STEP};
        return s[8] ? 8'h00 : s[7:0];
    endfunction

    function automatic logic [7:0] vol_up(input logic [7:0] v);
        logic [8:0] s;
        s = {1'b0, v} + {1'b0, VOL_STEP};
        return (s > {1'b0, VOL_MAX}) ? VOL_MAX : s[7:0];
    endfunction

    assign step_ok = (ho_q == 32'd0);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        vl_d    = vl_q;
        vr_d    = vr_q;
        muted_d = muted_q;
        ho_d    = (ho_q != 32'd0) ? ho_q - 32'd1 : ho_q;
        to_d    = to_q;
        chg_d   = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data >= 8'hA1 && rx_data <= TRK_HI) begin
                        cur_d = TRACK_W'(rx_data - 8'hA1);
                        chg_d = 1'b1;
                        ack_d = 1'b1;
                    end else if (rx_data[7:4] == 4'hA) begin
                        err_d = 1'b1;
                    end else begin
                        case (rx_data)
                            8'hB1: if (step_ok) begin
                                cur_d = (cur_q == '0) ? TRK_LAST : cur_q - TRACK_W'(1);
                                chg_d = 1'b1;
                                ack_d = 1'b1;
                                ho_d  = HO_LOAD;
                            end
                            8'hB2: if (step_ok) begin
                                cur_d = (cur_q == TRK_LAST) ? '0 : cur_q + TRACK_W'(1);
                                chg_d = 1'b1;
                                ack_d = 1'b1;
                                ho_d  = HO_LOAD;
                            end
                            8'hB3: if (step_ok) begin
                                vl_d  = vol_dn(vl_q);
                                vr_d  = vol_dn(vr_q);
                                ack_d = 1'b1;
                                ho_d  = HO_LOAD;
                            end
                            8'hB4: if (step_ok) begin
                                vl_d  = vol_up(vl_q);
                                vr_d  = vol_up(vr_q);
                                ack_d = 1'b1;
                                ho_d  = HO_LOAD;
                            end
                            8'hB0: begin
                                muted_d = ~muted_q;
                                ack_d   = 1'b1;
                            end
                            8'hC1: begin
                                state_d = WAIT_ARG;
                                to_d    = 32'd0;
                            end
                            8'h00: ;
                            default: err_d = 1'b1;
                        endcase
                    end
                end
            end
            WAIT_ARG: begin
                // A byte arriving on the timeout cycle still counts as the argument.
                if (rx_valid) begin
                    vl_d    = (rx_data > VOL_MAX) ? VOL_MAX : rx_data;
                    vr_d    = (rx_data > VOL_MAX) ? VOL_MAX : rx_data;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        vol_d = muted_d ? {MUTE_VAL, MUTE_VAL} : {vl_d, vr_d};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cur_q   <= '0;
            vl_q    <= VOL_RST;
            vr_q    <= VOL_RST;
            muted_q <= 1'b0;
            vol_q   <= {VOL_RST, VOL_RST};
            ho_q    <= 32'd0;
            to_q    <= 32'd0;
            chg_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            vl_q    <= vl_d;
            vr_q    <= vr_d;
            muted_q <= muted_d;
            vol_q   <= vol_d;
            ho_q    <= ho_d;
            to_q    <= to_d;
            chg_q   <= chg_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign vol       = vol_q;
    assign CURRENT   = cur_q;
    assign track_chg = chg_q;
    assign cmd_ack   = ack_q;
    assign cmd_err   = err_q;
    assign muted     = muted_q;

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// Directed bench for bt_cmd_ctrl with short hold-off and argument timeout.
module tb_bt_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [15:0] vol;
    logic [3:0]  CURRENT;
    logic        track_chg, cmd_ack, cmd_err, muted;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int ack_cnt  = 0;
    int err_cnt  = 0;
    int chg_cnt  = 0;
    int a0, e0, c0;
    int first_err;

    always #5 CLK = ~CLK;

    bt_cmd_ctrl #(
        .NUM_TRACKS (4),
        .TRACK_W    (4),
        .HOLDOFF    (10),
        .ARG_TIMEOUT(20)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .vol      (vol),
        .CURRENT  (CURRENT),
        .track_chg(track_chg),
        .cmd_ack  (cmd_ack),
        .cmd_err  (cmd_err),
        .muted    (muted)
    );

    always @(negedge CLK) begin
        if (cmd_ack)   ack_cnt <= ack_cnt + 1;
        if (cmd_err)   err_cnt <= err_cnt + 1;
        if (track_chg) chg_cnt <= chg_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        if (obs === exp) begin
            pass_cnt++;
            $display("check %-14s obs=%h exp=%h ok", tag, obs, exp);
        end else begin
            $display("FAIL %-14s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Byte is accepted on one rising edge; returns after the pulse has been counted.
    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
        @(negedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic snap();
        a0 = ack_cnt; e0 = err_cnt; c0 = chg_cnt;
    endtask

    initial begin
        #12;
        check_val("rst_vol", 32'(vol), 32'h2020);
        idle(2);
        RST = 1'b1;
        snap();
        idle(5);
        check_val("idle_vol", 32'(vol), 32'h2020);
        check_val("idle_cur", 32'(CURRENT), 0);
        check_val("idle_muted", 32'(muted), 0);
        check_val("idle_pulses", 32'(ack_cnt + err_cnt + chg_cnt - a0 - e0 - c0), 0);

        // Hold-off: accepted at E0, dropped at E3, accepted at E12.
        snap();
        send(8'hB2);
        check_val("b2_first", 32'(CURRENT), 1);
        idle(1);
        send(8'hB2);
        check_val("b2_drop_cur", 32'(CURRENT), 1);
        check_val("b2_drop_ack", 32'(ack_cnt - a0), 1);
        check_val("b2_drop_err", 32'(err_cnt - e0), 0);
        idle(7);
        send(8'hB2);
        check_val("b2_third", 32'(CURRENT), 2);
        check_val("b2_chg_cnt", 32'(chg_cnt - c0), 2);
        send(8'hA1);
        check_val("a1_direct", 32'(CURRENT), 0);
        idle(12);
        send(8'hB1);
        check_val("b1_wrap", 32'(CURRENT), 3);

        // Volume saturation.
        snap();
        send(8'hC1);
        send(8'h05);
        check_val("abs_05", 32'(vol), 32'h0505);
        check_val("abs_05_ack", 32'(ack_cnt - a0), 1);
        idle(12);
        send(8'hB3);
        check_val("b3_sat0", 32'(vol), 32'h0000);
        send(8'hC1);
        send(8'hFF);
        check_val("abs_ff", 32'(vol), 32'hF0F0);
        idle(12);
        snap();
        send(8'hB4);
        check_val("b4_satmax", 32'(vol), 32'hF0F0);
        check_val("b4_ack", 32'(ack_cnt - a0), 1);

        // Mute with restore, volume step applied underneath.
        send(8'hC1);
        send(8'h20);
        send(8'hB0);
        check_val("mute_vol", 32'(vol), 32'hFEFE);
        check_val("mute_flag", 32'(muted), 1);
        idle(12);
        send(8'hB3);
        check_val("mute_b3_vol", 32'(vol), 32'hFEFE);
        send(8'hB0);
        check_val("unmute_vol", 32'(vol), 32'h1010);
        check_val("unmute_flag", 32'(muted), 0);

        // Errors.
        snap();
        send(8'hA5);
        check_val("err_a5", 32'(err_cnt - e0), 1);
        check_val("err_a5_cur", 32'(CURRENT), 3);
        send(8'h7E);
        check_val("err_7e", 32'(err_cnt - e0), 2);
        check_val("err_7e_ack", 32'(ack_cnt - a0), 0);
        send(8'hC1);
        first_err = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK);
            #1;
            if (cmd_err) begin
                first_err = k;
                break;
            end
        end
        check_val("timeout_cyc", 32'(first_err), 20);
        check_val("timeout_vol", 32'(vol), 32'h1010);
        idle(2);
        send(8'hA2);
        check_val("after_to_cur", 32'(CURRENT), 1);

        // Asynchronous reset while waiting for an argument.
        send(8'hC1);
        send(8'h30);
        check_val("vol_3030", 32'(vol), 32'h3030);
        send(8'hC1);
        #2;
        RST = 1'b0;
        #1;
        check_val("arst_vol", 32'(vol), 32'h2020);
        check_val("arst_cur", 32'(CURRENT), 0);
        check_val("arst_muted", 32'(muted), 0);
        idle(1);
        RST = 1'b1;
        snap();
        send(8'h40);
        check_val("post_rst_err", 32'(err_cnt - e0), 1);
        check_val("post_rst_vol", 32'(vol), 32'h2020);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
